sha256_padder: RTL and testbench
================================

# sha256_padder

Front-end block that turns a byte stream of known length into padded 512-bit SHA-256 message blocks. It appends 0x80, zero fill and the 64-bit big-endian bit length, and presents each finished block through a valid/ready handshake. It also reports the total block count at start. It sits between the byte source and the sha256 core: `blk_data` feeds the core's message input, `num_blocks` feeds its block count, and `blk_ready` is driven from the core's next-block-read indication.

## Interface
- `LEN_W`, default 32: width of `msg_len` in bytes; legal range 6..61.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle pulse; accepted only in IDLE.
- `msg_len`  in  LEN_W  message length in bytes; sampled with `start`.
- `num_blocks`  out  64  block count, floor((msg_len+8)/64)+1; registered at accepted `start`.
- `in_data`  in  8  message byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  byte accepted when `in_valid && in_ready`.
- `in_last`  in  1  marks final byte; only checked when SHA256_PAD_LEN_CHECK_EN is defined.
- `blk_data`  out  512  padded block; byte k of the block is at bits [511-8k -: 8].
- `blk_valid`  out  1  block held stable until accepted.
- `blk_ready`  in  1  consumer takes the block when `blk_valid && blk_ready`.
- `blk_last`  out  1  qualifies `blk_valid`; marks the final block of the message.
- `busy`  out  1  high in any state other than IDLE.
- `err`  out  1  sticky length/last mismatch flag.

## Operation
- Reset values: all outputs 0, `num_blocks` 0, state IDLE.
- FSM states: IDLE, DATA, PAD80, ZERO, LEN.
- A 6-bit byte position `pos` writes one byte per cycle into the block register. After position 63 is written, `blk_valid` is set and `pos` wraps to 0.
- IDLE, `start` high: latch the length, clear `err` and `pos`. Go to DATA if `msg_len` != 0, otherwise to PAD80.
- DATA: write each accepted byte at `pos` and decrement `bytes_left`. Accepting the byte with `bytes_left`==1 moves the FSM to PAD80.
- PAD80: write 0x80 at `pos` for one cycle. Then go to LEN if the next `pos` is 56, otherwise to ZERO.
- ZERO: write 0x00 at `pos`. Leave for LEN when the next `pos` is 56. This includes wrapping through a block boundary when 0x80 landed at position 56 or later.
- LEN: write byte (`pos`-56) of the 64-bit value `msg_len`*8 (zero-extended, MSB first) over positions 56..63.
- When the LEN write at position 63 completes, the block is flagged `blk_last`=1, and the FSM returns to IDLE after that block handshakes.
- Stall: while `blk_valid` && !`blk_ready`, no byte is written, the FSM holds, and `in_ready`=0.
- `in_ready` = (state==DATA) && !`blk_valid`.
- `start` while `busy` is ignored.
- `rst` mid-message aborts immediately. Any partial block is discarded; nothing is emitted.

## Timing
- One byte per cycle when unstalled. Position p of a block is written in the cycle after position p-1.
- `blk_valid` rises the cycle after position 63 is written. It drops the cycle after the `blk_valid && blk_ready` handshake.
- A byte write to position 0 of the next block can occur in the same cycle as the handshake.
- `num_blocks` is valid the cycle after an accepted `start` and holds until the next accepted `start`.
- `busy` falls the cycle after the final block handshake.

## Configuration
- SHA256_PAD_LEN_CHECK_EN defined: `err` sets (sticky until the next accepted `start`) if either:
  - `in_last`=1 on a byte with `bytes_left` != 1, or
  - `in_last`=0 on the byte with `bytes_left`==1.
  - Padding still follows `msg_len`.
- Not defined: `in_last` is ignored and `err` is tied to 0.

## Structure
- Shared package `sha256_pkg`:
  - state enum;
  - `PAD_BYTE`=8'h80, `LEN_POS`=56, `BLOCK_BYTES`=64.
- Sub-module `sha256_byte_packer`: the 512-bit block register with byte-position write, `pos` counter and valid/ready hold. The top level holds the FSM and the length logic.

## Test plan
- "abc", `msg_len`=3, no stall, `blk_ready`=1:
  - `num_blocks`=1;
  - one block 0x61626380 followed by zeros, low 64 bits 0x18, `blk_last`=1;
  - `blk_valid` at cycle 65 after `start`.
- `msg_len`=0 → `num_blocks`=1; block 0x80 followed by 55 zero bytes and a 64-bit length field of 0.
- `msg_len`=55 → `num_blocks`=1; 0x80 at byte 55, length 0x1B8 in bytes 56..63.
- `msg_len`=56 → `num_blocks`=2:
  - block 0 has 0x80 at byte 56 then zeros, `blk_last`=0;
  - block 1 is all zeros except length 0x1C0, `blk_last`=1.
- Backpressure: hold `blk_ready`=0 for 10 cycles on a 130-byte message → `in_ready`=0 and `blk_data` stable throughout; the 3 blocks arrive in order and match reference digests through the core.
- With SHA256_PAD_LEN_CHECK_EN: `msg_len`=4 with `in_last` on byte 2 → `err`=1, output block still padded per length 4. Assert `rst` mid-DATA → all outputs 0, no block emitted.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared state encoding, padding constants and length-field helper for the
// SHA-256 message padder.
package sha256_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DATA  = 3'd1,
    ST_PAD80 = 3'd2,
    ST_ZERO  = 3'd3,
    ST_LEN   = 3'd4
  } pad_state_e;

  localparam logic [7:0] PAD_BYTE    = 8'h80;
  localparam logic [5:0] LEN_POS     = 6'd56;
  localparam int         BLOCK_BYTES = 64;
  localparam logic [5:0] LAST_POS    = 6'(BLOCK_BYTES - 1);

  // Byte idx (0 = most significant) of the 64-bit big-endian bit length.
  function automatic logic [7:0] len_byte(input logic [63:0] bits, input logic [2:0] idx);
    logic [63:0] shifted;
    shifted = bits >> {3'd7 - idx, 3'b000};
    return shifted[7:0];
  endfunction

endpackage

// File: rtl/sha256_byte_packer.sv
// 512-bit block register filled one byte per cycle at a wrapping position,
// holding the finished block until the consumer takes it.
module sha256_byte_packer
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_wr_en,
  input  logic [7:0]   i_wr_byte,
  input  logic         i_wr_last,
  input  logic         i_ready,
  output logic [511:0] o_blk,
  output logic [5:0]   o_pos,
  output logic         o_valid,
  output logic         o_last
);

  logic [511:0] r_blk;
  logic [5:0]   r_pos;
  logic         r_valid;
  logic         r_last;
  logic [8:0]   w_msb;

  // Byte p lives at bits [511-8p -: 8]; 511-8p equals {~p, 3'b111}.
  assign w_msb = {~r_pos, 3'b111};

  // Block storage, write position and valid/last hold; a write to byte 0 may
  // share the cycle with the handshake of the previous block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blk   <= 512'd0;
      r_pos   <= 6'd0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_clr) begin
      r_pos   <= 6'd0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      if (r_valid && i_ready) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
      if (i_wr_en) begin
        r_blk[w_msb -: 8] <= i_wr_byte;
        r_pos             <= r_pos + 6'd1;
        if (r_pos == LAST_POS) begin
          r_valid <= 1'b1;
          r_last  <= i_wr_last;
        end
      end
    end
  end

  assign o_blk   = r_blk;
  assign o_pos   = r_pos;
  assign o_valid = r_valid;
  assign o_last  = r_last;

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 message padder: byte stream in, padded 512-bit blocks out.
// Optional in_last/length consistency check: define SHA256_PAD_LEN_CHECK_EN.
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 32
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_msg_len,
  output logic [63:0]      o_num_blocks,
  input  logic [7:0]       i_in_data,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic             i_in_last,
  output logic [511:0]     o_blk_data,
  output logic             o_blk_valid,
  input  logic             i_blk_ready,
  output logic             o_blk_last,
  output logic             o_busy,
  output logic             o_err
);

  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};

  pad_state_e       r_state;
  pad_state_e       w_next;
  logic [LEN_W-1:0] r_bytes_left;
  logic [63:0]      r_len_bits;
  logic [63:0]      r_num_blocks;
  logic             r_err;

  logic [63:0]  w_len_ext;
  logic         w_start_acc;
  logic         w_accept;
  logic         w_err_set;
  logic         w_wr_en;
  logic [7:0]   w_wr_byte;
  logic         w_wr_last;
  logic         w_stall;
  logic [5:0]   w_pos;
  logic         w_blk_valid;
  logic         w_blk_last;
  logic [511:0] w_blk_data;

  assign w_len_ext = 64'(i_msg_len);
  assign w_stall   = w_blk_valid && !i_blk_ready;

  sha256_byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_start_acc),
    .i_wr_en   (w_wr_en),
    .i_wr_byte (w_wr_byte),
    .i_wr_last (w_wr_last),
    .i_ready   (i_blk_ready),
    .o_blk     (w_blk_data),
    .o_pos     (w_pos),
    .o_valid   (w_blk_valid),
    .o_last    (w_blk_last)
  );

  // Next-state and byte-write selection for the padding sequence.
  always_comb begin
    w_next      = r_state;
    w_start_acc = 1'b0;
    w_accept    = 1'b0;
    w_err_set   = 1'b0;
    w_wr_en     = 1'b0;
    w_wr_byte   = 8'h00;
    w_wr_last   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_start_acc = 1'b1;
          w_next      = (i_msg_len != LEN_ZERO) ? ST_DATA : ST_PAD80;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (!w_blk_valid && i_in_valid) begin
          w_accept  = 1'b1;
          w_wr_en   = 1'b1;
          w_wr_byte = i_in_data;
`ifdef SHA256_PAD_LEN_CHECK_EN
          w_err_set = (i_in_last != (r_bytes_left == LEN_ONE));
`endif
          if (r_bytes_left == LEN_ONE) begin
            w_next = ST_PAD80;
          end else begin
            w_next = ST_DATA;
          end
        end else begin
          w_next = ST_DATA;
        end
      end
      ST_PAD80: begin
        if (!w_stall) begin
          w_wr_en   = 1'b1;
          w_wr_byte = PAD_BYTE;
          w_next    = ((w_pos + 6'd1) == LEN_POS) ? ST_LEN : ST_ZERO;
        end else begin
          w_next = ST_PAD80;
        end
      end
      ST_ZERO: begin
        // Zero fill may wrap through a block boundary before reaching 56.
        if (!w_stall) begin
          w_wr_en = 1'b1;
          if ((w_pos + 6'd1) == LEN_POS) begin
            w_next = ST_LEN;
          end else begin
            w_next = ST_ZERO;
          end
        end else begin
          w_next = ST_ZERO;
        end
      end
      ST_LEN: begin
        // Only the final block can be pending here; wait for its handshake.
        if (w_blk_valid) begin
          if (i_blk_ready) begin
            w_next = ST_IDLE;
          end else begin
            w_next = ST_LEN;
          end
        end else begin
          w_wr_en   = 1'b1;
          w_wr_byte = len_byte(r_len_bits, w_pos[2:0]);
          w_wr_last = 1'b1;
          w_next    = ST_LEN;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // State register plus length bookkeeping latched at an accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_bytes_left <= LEN_ZERO;
      r_len_bits   <= 64'd0;
      r_num_blocks <= 64'd0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start_acc) begin
        r_bytes_left <= i_msg_len;
        r_len_bits   <= w_len_ext << 3;
        r_num_blocks <= ((w_len_ext + 64'd8) >> 6) + 64'd1;
        r_err        <= 1'b0;
      end else begin
        if (w_accept) begin
          r_bytes_left <= r_bytes_left - LEN_ONE;
        end
        if (w_err_set) begin
          r_err <= 1'b1;
        end
      end
    end
  end

`ifndef SHA256_PAD_LEN_CHECK_EN
  logic w_unused_last;
  assign w_unused_last = i_in_last;
`endif

  assign o_num_blocks = r_num_blocks;
  assign o_in_ready   = (r_state == ST_DATA) && !w_blk_valid;
  assign o_blk_data   = w_blk_data;
  assign o_blk_valid  = w_blk_valid;
  assign o_blk_last   = w_blk_last;
  assign o_busy       = (r_state != ST_IDLE);
`ifdef SHA256_PAD_LEN_CHECK_EN
  assign o_err        = r_err;
`else
  assign o_err        = 1'b0;
`endif

endmodule

// File: tb/tb_sha256_padder.sv
// Directed self-checking bench for sha256_padder: known padded blocks,
// block counts, first-block latency, backpressure, length check and reset abort.
`timescale 1ns/1ps
module tb_sha256_padder;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_start;
  logic [31:0]  i_msg_len;
  logic [63:0]  o_num_blocks;
  logic [7:0]   i_in_data;
  logic         i_in_valid;
  logic         o_in_ready;
  logic         i_in_last;
  logic [511:0] o_blk_data;
  logic         o_blk_valid;
  logic         i_blk_ready;
  logic         o_blk_last;
  logic         o_busy;
  logic         o_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]   msg      [0:255];
  logic [7:0]   exp_b    [0:255];
  logic [511:0] cap_blk  [0:3];
  logic         cap_last [0:3];
  int           cap_n;
  bit           saw;

  always #5 clk = ~clk;

  sha256_padder #(.LEN_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_msg_len    (i_msg_len),
    .o_num_blocks (o_num_blocks),
    .i_in_data    (i_in_data),
    .i_in_valid   (i_in_valid),
    .o_in_ready   (o_in_ready),
    .i_in_last    (i_in_last),
    .o_blk_data   (o_blk_data),
    .o_blk_valid  (o_blk_valid),
    .i_blk_ready  (i_blk_ready),
    .o_blk_last   (o_blk_last),
    .o_busy       (o_busy),
    .o_err        (o_err)
  );

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference padding of msg[0:len-1] into exp_b.
  task automatic build_exp(input int len);
    int          total;
    logic [63:0] bits;
    total = ((len + 8) / 64 + 1) * 64;
    for (int i = 0; i < 256; i++) exp_b[i] = 8'h00;
    for (int i = 0; i < len; i++) exp_b[i] = msg[i];
    exp_b[len] = 8'h80;
    bits = 64'(len) * 64'd8;
    for (int k = 0; k < 8; k++) exp_b[total - 8 + k] = bits[63 - 8 * k -: 8];
  endtask

  function automatic logic [511:0] exp_block(input int k);
    logic [511:0] b;
    for (int j = 0; j < 64; j++) b[511 - 8 * j -: 8] = exp_b[64 * k + j];
    return b;
  endfunction

  task automatic fill_msg(input int len);
    for (int i = 0; i < len; i++) msg[i] = 8'(i * 37 + 5);
  endtask

  task automatic run_msg(input string name, input int len, input int last_idx,
                         input bit stall_en, input int exp_nblk, input int exp_first);
    int           idx;
    int           first_valid;
    int           stall_cnt;
    bit           done;
    logic [511:0] hold;
    idx = 0; first_valid = -1; stall_cnt = 0; done = 1'b0; cap_n = 0; hold = 512'd0;
    build_exp(len);
    @(negedge clk);
    i_msg_len = 32'(len);
    i_start   = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check({name, "_nblk"}, 512'(o_num_blocks), 512'(exp_nblk));
    check({name, "_busy"}, 512'(o_busy), 512'd1);
    for (int n = 0; n < 1000 && !done; n++) begin
      if (o_blk_valid && first_valid < 0) first_valid = n;
      if (o_blk_valid && stall_en && stall_cnt < 10) begin
        if (stall_cnt == 0) hold = o_blk_data;
        else check({name, "_stall_data"}, o_blk_data, hold);
        check({name, "_stall_in_ready"}, 512'(o_in_ready), 512'd0);
        stall_cnt++;
        i_blk_ready = 1'b0;
      end else begin
        i_blk_ready = 1'b1;
        if (o_blk_valid) begin
          if (cap_n < 4) begin
            cap_blk[cap_n]  = o_blk_data;
            cap_last[cap_n] = o_blk_last;
          end
          cap_n++;
          if (o_blk_last) done = 1'b1;
        end
      end
      i_in_valid = (idx < len);
      i_in_data  = msg[idx[7:0]];
      i_in_last  = (idx == last_idx);
      if (i_in_valid && o_in_ready) idx++;
      @(negedge clk);
    end
    i_in_valid = 1'b0;
    i_in_last  = 1'b0;
    check({name, "_done"}, 512'(done), 512'd1);
    check({name, "_busy_end"}, 512'(o_busy), 512'd0);
    check({name, "_nblk_cap"}, 512'(cap_n), 512'(exp_nblk));
    if (exp_first >= 0) check({name, "_first_valid"}, 512'(first_valid), 512'(exp_first));
    for (int k = 0; k < exp_nblk && k < cap_n && k < 4; k++) begin
      check({name, "_blk"}, cap_blk[k], exp_block(k));
      check({name, "_last"}, 512'(cap_last[k]), 512'(k == exp_nblk - 1));
    end
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_msg_len = 32'd0; i_in_data = 8'h00;
    i_in_valid = 1'b0; i_in_last = 1'b0; i_blk_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 512'(o_blk_valid), 512'd0);
    check("rst_data", o_blk_data, 512'd0);
    check("rst_nblk", 512'(o_num_blocks), 512'd0);
    check("rst_busy", 512'(o_busy), 512'd0);
    check("rst_in_ready", 512'(o_in_ready), 512'd0);
    rst = 1'b0;

    // "abc": single block, first blk_valid 64 edges after the start-sampling edge.
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    run_msg("abc", 3, 2, 1'b0, 1, 64);
    check("abc_const", cap_blk[0], {32'h61626380, 416'd0, 64'h18});
    check("abc_err", 512'(o_err), 512'd0);

    run_msg("len0", 0, -1, 1'b0, 1, -1);
    check("len0_const", cap_blk[0], {8'h80, 504'd0});

    fill_msg(55);
    run_msg("len55", 55, 54, 1'b0, 1, -1);
    check("len55_pad", 512'(cap_blk[0][71:64]), 512'h80);
    check("len55_len", 512'(cap_blk[0][63:0]), 512'h1B8);

    fill_msg(56);
    run_msg("len56", 56, 55, 1'b0, 2, -1);
    check("len56_pad", 512'(cap_blk[0][63:56]), 512'h80);
    check("len56_zero", 512'(cap_blk[0][55:0]), 512'd0);
    check("len56_blk1", cap_blk[1], {448'd0, 64'h1C0});

    fill_msg(130);
    run_msg("bp130", 130, 129, 1'b1, 3, -1);

    // in_last on the second byte of a four-byte message.
    fill_msg(4);
    run_msg("lenchk", 4, 1, 1'b0, 1, -1);
`ifdef SHA256_PAD_LEN_CHECK_EN
    check("lenchk_err", 512'(o_err), 512'd1);
`else
    check("lenchk_err", 512'(o_err), 512'd0);
`endif

    // Abort mid-DATA with reset.
    fill_msg(100);
    @(negedge clk);
    i_msg_len = 32'd100; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0; i_in_valid = 1'b1; i_blk_ready = 1'b1; i_in_data = 8'h5A;
    repeat (10) @(negedge clk);
    check("abort_busy_pre", 512'(o_busy), 512'd1);
    rst = 1'b1;
    #1;
    check("abort_valid", 512'(o_blk_valid), 512'd0);
    check("abort_data", o_blk_data, 512'd0);
    check("abort_nblk", 512'(o_num_blocks), 512'd0);
    check("abort_busy", 512'(o_busy), 512'd0);
    check("abort_in_ready", 512'(o_in_ready), 512'd0);
    check("abort_last", 512'(o_blk_last), 512'd0);
    check("abort_err", 512'(o_err), 512'd0);
    @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (o_blk_valid || o_busy) saw = 1'b1;
    end
    check("abort_no_block", 512'(saw), 512'd0);
    i_in_valid = 1'b0;

    // Recovery after abort; also clears a sticky err from the earlier run.
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    run_msg("abc2", 3, 2, 1'b0, 1, 64);
    check("abc2_const", cap_blk[0], {32'h61626380, 416'd0, 64'h18});
    check("abc2_err", 512'(o_err), 512'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
